// File: rtl/conv_seq_ctrl_if.sv
// SRAM read port plus ifmap stream between the sequencer and its neighbours.
// master = sequencer side, slave = SRAM/conv engine side.
interface conv_seq_ctrl_if #(
  parameter int ADDR_W = 13
);
  logic              sram_rd_en;
  logic [ADDR_W-1:0] sram_rd_addr;
  logic [31:0]       sram_rd_data;
  logic [31:0]       ifmap_data;
  logic              ifmap_valid;
  logic              ifmap_ready;

  modport master (
    output sram_rd_en,
    output sram_rd_addr,
    input  sram_rd_data,
    output ifmap_data,
    output ifmap_valid,
    input  ifmap_ready
  );

  modport slave (
    input  sram_rd_en,
    input  sram_rd_addr,
    output sram_rd_data,
    input  ifmap_data,
    input  ifmap_valid,
    output ifmap_ready
  );
endinterface

// File: rtl/conv_seq_ctrl.sv
// Conv input sequencer: weight bank load, then backpressured ifmap stream.
// Abortable; one-cycle done pulse at the end of a completed run.
module conv_seq_ctrl #(
  parameter int ADDR_W      = 13,
  parameter int WEIGHT_BASE = 4080,
  parameter int N_TAPS      = 9,
  parameter int IFMAP_WORDS = 480
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [N_TAPS*32-1:0] weight_data,
  output logic                 weight_valid,
  conv_seq_ctrl_if.master      bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WLOAD  = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;
  localparam logic [1:0] FIN    = 2'd3;

  localparam logic [4:0]        NT   = 5'(N_TAPS);
  localparam logic [ADDR_W-1:0] WB   = ADDR_W'(WEIGHT_BASE);
  localparam logic [ADDR_W-1:0] NW   = ADDR_W'(IFMAP_WORDS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IFMAP_WORDS - 1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  logic [1:0]        state;
  logic [4:0]        wcnt;
  logic              wpend;
  logic [ADDR_W-1:0] raddr;
  logic [ADDR_W-1:0] bcnt;
  logic              spend;
  logic [1:0]        occ;
  logic [31:0]       f0;
  logic [31:0]       f1;
  logic [31:0]       bank [N_TAPS];

  logic       wrd;
  logic       srd;
  logic       pop;
  logic [2:0] fill;
  logic [4:0] slot;

  always_comb begin
    wrd  = (state == WLOAD) && (wcnt < NT);
    pop  = (occ != 2'd0) && bus.ifmap_ready;
    fill = {1'b0, occ} + {2'b0, spend};
    // fill counts queued plus in-flight words; a same-cycle pop frees a slot
    srd  = (state == STREAM) && (raddr < NW) &&
           ((fill < 3'd2) || ((fill == 3'd2) && pop));
    slot = wcnt - 5'd1;
  end

  assign bus.sram_rd_en   = wrd | srd;
  assign bus.sram_rd_addr = wrd ? WB + {{(ADDR_W-5){1'b0}}, wcnt}
                          : srd ? raddr : '0;
  assign bus.ifmap_valid  = (occ != 2'd0);
  assign bus.ifmap_data   = f0;
  assign busy             = (state != IDLE);
  assign done             = (state == FIN) && !abort;

  for (genvar i = 0; i < N_TAPS; i++) begin : g_w
    assign weight_data[32*i +: 32] = bank[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wcnt         <= '0;
      wpend        <= 1'b0;
      raddr        <= '0;
      bcnt         <= '0;
      spend        <= 1'b0;
      occ          <= '0;
      f0           <= '0;
      f1           <= '0;
      weight_valid <= 1'b0;
      for (int i = 0; i < N_TAPS; i++) bank[i] <= '0;
    end else if (abort) begin
      state <= IDLE;
      wcnt  <= '0;
      wpend <= 1'b0;
      raddr <= '0;
      bcnt  <= '0;
      spend <= 1'b0;
      occ   <= '0;
      if (state == WLOAD) weight_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state        <= WLOAD;
            weight_valid <= 1'b0;
            wcnt         <= '0;
            raddr        <= '0;
            bcnt         <= '0;
            occ          <= '0;
            for (int i = 0; i < N_TAPS; i++) bank[i] <= '0;
          end
        end
        WLOAD: begin
          wpend <= wrd;
          if (wrd) wcnt <= wcnt + 5'd1;
          for (int i = 0; i < N_TAPS; i++)
            if (wpend && slot == 5'(i)) bank[i] <= bus.sram_rd_data;
          if (wcnt == NT) begin
            state        <= STREAM;
            weight_valid <= 1'b1;
            wcnt         <= '0;
          end
        end
        STREAM: begin
          spend <= srd;
          if (srd) raddr <= raddr + ONE;
          unique case ({spend, pop})
            2'b11: begin
              if (occ == 2'd1) f0 <= bus.sram_rd_data;
              else begin
                f0 <= f1;
                f1 <= bus.sram_rd_data;
              end
            end
            2'b10: begin
              if (occ == 2'd0) f0 <= bus.sram_rd_data;
              else f1 <= bus.sram_rd_data;
              occ <= occ + 2'd1;
            end
            2'b01: begin
              f0  <= f1;
              occ <= occ - 2'd1;
            end
            default: ;
          endcase
          if (pop) begin
            bcnt <= bcnt + ONE;
            if (bcnt == LAST) begin
              state <= FIN;
              bcnt  <= '0;
              raddr <= '0;
            end
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
